// File: rtl/la_txser_pkg.sv
// la_txser shared definitions: FSM state codes and line idle level.
// Optional parity build switch: LA_TXSER_PARITY_EN.
package la_txser_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/la_txser_baud.sv
// la_txser bit-period down-counter; tick marks the last cycle of a bit.
// Reloaded on word accept and at every bit boundary.
module la_txser_baud #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          load,
  input  logic [CW-1:0] val,
  output logic          tick
);

  logic [CW-1:0] cnt_q;

  // load the period, otherwise count down and rest at zero
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/la_txser.sv
// la_txser framed serial transmitter (start, data LSB first, stop).
// Define LA_TXSER_PARITY_EN to insert an even-parity bit before stop.
module la_txser
  import la_txser_pkg::*;
#(
  parameter string PROP = "DEFAULT",
  parameter int    DW   = 8,
  parameter int    CW   = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          en,
  input  logic [CW-1:0] div,
  input  logic          valid,
  input  logic [DW-1:0] data,
  output logic          ready,
  output logic          busy,
  output logic          sout
);

  localparam int BW = $clog2(DW) + 1;
  localparam logic [BW-1:0] LAST = BW'(DW - 1);

  logic [2:0]    state_q;
  logic [DW-1:0] shift_q;
  logic [DW-1:0] shift_d;
  logic [BW-1:0] idx_q;
  logic [CW-1:0] div_q;
  logic          sout_q;
  logic          busy_q;
  logic          init_q;
`ifdef LA_TXSER_PARITY_EN
  logic          par_q;
`endif

  logic          tick;
  logic          accept;
  logic          bload;
  logic [CW-1:0] bval;

  assign ready = en & init_q &
                 ((state_q == S_IDLE) |
                  ((state_q == S_STOP) & tick));
  assign accept = valid & ready;
  assign bload = accept | (tick & (state_q != S_IDLE));
  assign bval = accept ? div : div_q;
  assign shift_d = shift_q >> 1;

  la_txser_baud #(
    .CW(CW)
  ) u_baud (
    .clk   (clk),
    .nreset(nreset),
    .load  (bload),
    .val   (bval),
    .tick  (tick)
  );

  // frame sequencer; init_q holds ready low for the first cycle after reset
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      div_q   <= '0;
      sout_q  <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      init_q  <= 1'b0;
`ifdef LA_TXSER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      init_q <= 1'b1;
      if (accept) begin
        state_q <= S_START;
        shift_q <= data;
        div_q   <= div;
        sout_q  <= ~IDLE_LEVEL;
        busy_q  <= 1'b1;
`ifdef LA_TXSER_PARITY_EN
        par_q   <= ^data;
`endif
      end else if (tick) begin
        case (state_q)
          S_START: begin
            state_q <= S_DATA;
            idx_q   <= '0;
            sout_q  <= shift_q[0];
          end
          S_DATA: begin
            if (idx_q == LAST) begin
`ifdef LA_TXSER_PARITY_EN
              state_q <= S_PARITY;
              sout_q  <= par_q;
`else
              state_q <= S_STOP;
              sout_q  <= IDLE_LEVEL;
`endif
            end else begin
              idx_q   <= idx_q + 1'b1;
              shift_q <= shift_d;
              sout_q  <= shift_d[0];
            end
          end
`ifdef LA_TXSER_PARITY_EN
          S_PARITY: begin
            state_q <= S_STOP;
            sout_q  <= IDLE_LEVEL;
          end
`endif
          S_STOP: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy = busy_q;
  assign sout = sout_q;

endmodule

// File: tb/tb_la_txser.sv
// la_txser bench: reset, frame table, back-to-back, enable and reset cases.
// Expected frames are hand-written constants, first bit on the left.
module tb_la_txser;

`ifdef LA_TXSER_PARITY_EN
  localparam int NB = 11;
  localparam logic [NB-1:0] F_A5 = 11'b01010010101;
  localparam logic [NB-1:0] F_01 = 11'b01000000011;
  localparam logic [NB-1:0] F_80 = 11'b00000000111;
  localparam logic [NB-1:0] F_3C = 11'b00011110001;
  localparam logic [NB-1:0] F_FF = 11'b01111111101;
  localparam logic [NB-1:0] F_55 = 11'b01010101001;
  localparam logic [NB-1:0] F_AA = 11'b00101010101;
`else
  localparam int NB = 10;
  localparam logic [NB-1:0] F_A5 = 10'b0101001011;
  localparam logic [NB-1:0] F_01 = 10'b0100000001;
  localparam logic [NB-1:0] F_80 = 10'b0000000011;
  localparam logic [NB-1:0] F_3C = 10'b0001111001;
  localparam logic [NB-1:0] F_FF = 10'b0111111111;
  localparam logic [NB-1:0] F_55 = 10'b0101010101;
  localparam logic [NB-1:0] F_AA = 10'b0010101011;
`endif

  typedef struct {
    logic [7:0]    d;
    logic [7:0]    dv;
    logic [NB-1:0] frm;
  } vec_t;

  logic       clk = 1'b0;
  logic       nreset;
  logic       en;
  logic [7:0] div;
  logic       valid;
  logic [7:0] data;
  logic       ready;
  logic       busy;
  logic       sout;

  int nvec = 0;
  int nerr = 0;
  vec_t tbl[5];

  la_txser #(
    .PROP("DEFAULT"),
    .DW  (8),
    .CW  (8)
  ) dut (
    .clk   (clk),
    .nreset(nreset),
    .en    (en),
    .div   (div),
    .valid (valid),
    .data  (data),
    .ready (ready),
    .busy  (busy),
    .sout  (sout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %b want %b", nm, $time, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", ready, 1'b1);
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] dv,
                      input logic [NB-1:0] frm);
    int len;
    len = NB * (int'(dv) + 1);
    wait_ready();
    valid = 1'b1;
    data = d;
    div = dv;
    @(negedge clk);
    valid = 1'b0;
    div = 8'd0;
    data = ~d;
    for (int k = 0; k < len; k++) begin
      chk("frame_sout", sout, frm[NB-1-k/(int'(dv)+1)]);
      chk("frame_busy", busy, 1'b1);
      @(negedge clk);
    end
    chk("end_busy", busy, 1'b0);
    chk("end_sout", sout, 1'b1);
  endtask

  initial begin
    int len;
    tbl[0] = '{8'hA5, 8'd0, F_A5};
    tbl[1] = '{8'h01, 8'd3, F_01};
    tbl[2] = '{8'h80, 8'd1, F_80};
    tbl[3] = '{8'h3C, 8'd2, F_3C};
    tbl[4] = '{8'hFF, 8'd0, F_FF};

    nreset = 1'b0;
    en = 1'b1;
    valid = 1'b1;
    data = 8'hA5;
    div = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_sout", sout, 1'b1);
    chk("rst_ready", ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    nreset = 1'b1;
    #1;
    chk("rel_ready0", ready, 1'b0);
    @(negedge clk);
    chk("rel_ready1", ready, 1'b1);
    chk("rel_busy", busy, 1'b0);
    valid = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      send(tbl[i].d, tbl[i].dv, tbl[i].frm);
    end

    len = NB * 2;
    wait_ready();
    valid = 1'b1;
    data = 8'h55;
    div = 8'd1;
    @(negedge clk);
    data = 8'hAA;
    for (int k = 0; k < 2 * len; k++) begin
      if (k < len)
        chk("b2b_sout", sout, F_55[NB-1-k/2]);
      else
        chk("b2b_sout", sout, F_AA[NB-1-(k-len)/2]);
      chk("b2b_ready", ready, (k == len - 1) || (k == 2 * len - 1));
      chk("b2b_busy", busy, 1'b1);
      if (k == len) valid = 1'b0;
      @(negedge clk);
    end
    chk("b2b_end", busy, 1'b0);

    wait_ready();
    valid = 1'b1;
    data = 8'hFF;
    div = 8'd0;
    @(negedge clk);
    for (int k = 0; k < NB; k++) begin
      chk("en_sout", sout, F_FF[NB-1-k]);
      chk("en_ready", ready, 1'b0);
      if (k == 2) en = 1'b0;
      @(negedge clk);
    end
    for (int k = 0; k < 5; k++) begin
      chk("en_idle_sout", sout, 1'b1);
      chk("en_idle_ready", ready, 1'b0);
      chk("en_idle_busy", busy, 1'b0);
      @(negedge clk);
    end
    valid = 1'b0;
    en = 1'b1;
    @(negedge clk);

    wait_ready();
    valid = 1'b1;
    data = 8'h00;
    div = 8'd3;
    @(negedge clk);
    valid = 1'b0;
    repeat (17) @(negedge clk);
    chk("mid_bit3", sout, 1'b0);
    nreset = 1'b0;
    #1;
    chk("mid_rst_sout", sout, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", ready, 1'b0);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    send(8'h3C, 8'd2, F_3C);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
